// File: rtl/channel_batch_packer.sv
// -----------------------------------------------------------------------------
// channel_batch_packer
//
// Packs the decoded pixel stream into per-channel batches of CHANNEL_BANDWIDTH
// bits (PPB = CHANNEL_BANDWIDTH/PIXEL_WIDTH pixels per batch) and issues one
// global batch address per completed batch. Batches are numbered from 0 at
// each frame start, up to BANK_DEPTH*CHANNEL_NUMBER batches per frame.
// Assumes PPB >= 2.
//
// Ports
//   I_clk          pixel clock
//   I_rst          synchronous reset, active-high
//   I_frame_start  one-cycle pulse marking the first pixel of a frame
//   I_pixel_valid  a pixel is present this cycle
//   I_pixel_data   one sample per channel
//   O_data_out     completed batch per channel (first pixel in the LSBs)
//   O_address_out  global batch address of O_data_out
//   O_clk_out      batch strobe, rises one cycle after data/address change
//   O_drop         one-cycle pulse when a partial batch is discarded
//   O_overflow     sticky: a pixel arrived after the frame was full
// -----------------------------------------------------------------------------
module channel_batch_packer #(
   parameter int CHANNEL_NUMBER    = 3,
   parameter int CHANNEL_BANDWIDTH = 128,
   parameter int BANK_DEPTH        = 480,
   parameter int PIXEL_WIDTH       = 8
) (
   input  logic                                              I_clk,
   input  logic                                              I_rst,
   input  logic                                              I_frame_start,
   input  logic                                              I_pixel_valid,
   input  logic [PIXEL_WIDTH-1:0]                            I_pixel_data [0:CHANNEL_NUMBER-1],
   output logic [CHANNEL_BANDWIDTH-1:0]                      O_data_out   [0:CHANNEL_NUMBER-1],
   output logic [$clog2(BANK_DEPTH*CHANNEL_NUMBER)-1:0]      O_address_out,
   output logic                                              O_clk_out,
   output logic                                              O_drop,
   output logic                                              O_overflow
);

   localparam int PPB      = CHANNEL_BANDWIDTH / PIXEL_WIDTH;
   localparam int CAPACITY = BANK_DEPTH * CHANNEL_NUMBER;
   localparam int LANE_W   = (PPB > 1) ? $clog2(PPB) : 1;
   localparam int ADDR_W   = $clog2(CAPACITY);

   localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PPB - 1);
   localparam logic [ADDR_W-1:0] LAST_BATCH = ADDR_W'(CAPACITY - 1);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t                       state, next_state;
   logic [LANE_W-1:0]            lane;
   logic [LANE_W-1:0]            eff_lane;
   logic [ADDR_W-1:0]            batch;
   logic                         pending;     // completion seen, strobe due next cycle
   logic                         accept;
   logic                         complete;
   logic                         restart;
   logic                         drop_next;
   logic                         ovf_set;
   logic [CHANNEL_BANDWIDTH-1:0] shift_buf [0:CHANNEL_NUMBER-1];
   logic [CHANNEL_BANDWIDTH-1:0] buf_next  [0:CHANNEL_NUMBER-1];

   // Next-state and per-cycle control.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      next_state = state;
      accept     = 1'b0;
      complete   = 1'b0;
      restart    = 1'b0;
      drop_next  = 1'b0;
      eff_lane   = lane;
      case (state)
         IDLE, FULL: begin
            if (I_frame_start) begin
               next_state = FILL;
               restart    = 1'b1;
               accept     = I_pixel_valid;
               eff_lane   = '0;
            end
         end
         FILL: begin
            accept   = I_pixel_valid;
            complete = I_pixel_valid && (lane == LAST_LANE);
            if (I_frame_start) begin
               // A completing pixel finishes the old batch; otherwise the
               // frame start pixel opens lane 0 and any partial batch is lost.
               restart = 1'b1;
               if (!complete) begin
                  drop_next = (lane != '0);
                  eff_lane  = '0;
               end
            end else if (complete && batch == LAST_BATCH) begin
               next_state = FULL;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign ovf_set = (state == FULL) && I_pixel_valid && !I_frame_start;

   // Buffer image with the current pixel inserted at its lane, so the
   // completing pixel lands in O_data_out on the same edge.
   always_comb begin
      for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
         buf_next[ch] = shift_buf[ch];
         buf_next[ch][int'(eff_lane) * PIXEL_WIDTH +: PIXEL_WIDTH] = I_pixel_data[ch];
      end
   end

   // NOTE: the packing buffer has no reset; every lane is rewritten before a
   // batch can complete, so its contents after reset are never observed.
   always_ff @(posedge I_clk) begin
      if (accept) begin
         for (int ch = 0; ch < CHANNEL_NUMBER; ch++) shift_buf[ch] <= buf_next[ch];
      end
   end

   always_ff @(posedge I_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (I_rst) begin
         state         <= IDLE;
         lane          <= '0;
         batch         <= '0;
         pending       <= 1'b0;
         O_clk_out     <= 1'b0;
         O_drop        <= 1'b0;
         O_overflow    <= 1'b0;
         O_address_out <= '0;
         for (int ch = 0; ch < CHANNEL_NUMBER; ch++) O_data_out[ch] <= '0;
      end else begin
         state     <= next_state;
         pending   <= complete;
         O_clk_out <= pending;
         O_drop    <= drop_next;

         if (restart)      O_overflow <= 1'b0;
         else if (ovf_set) O_overflow <= 1'b1;

         if (complete) begin
            O_address_out <= batch;
            for (int ch = 0; ch < CHANNEL_NUMBER; ch++) O_data_out[ch] <= buf_next[ch];
         end

         if (restart) begin
            batch <= '0;
            lane  <= (accept && !complete) ? LANE_W'(1) : '0;
         end else if (complete) begin
            lane <= '0;
            if (batch != LAST_BATCH) batch <= batch + 1'b1;
         end else if (accept) begin
            lane <= lane + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_channel_batch_packer.sv
// -----------------------------------------------------------------------------
// tb_channel_batch_packer
//
// Self-checking bench for channel_batch_packer with default parameters.
// A queue-based reference model predicts every output each cycle; directed
// sequences and a scenario table cover frame-start, completion and overflow
// corners; a random phase exercises mixed traffic and resets.
// -----------------------------------------------------------------------------
module tb_channel_batch_packer;

   localparam int CH  = 3;
   localparam int BW  = 128;
   localparam int PW  = 8;
   localparam int BD  = 480;
   localparam int PPB = BW / PW;
   localparam int CAP = BD * CH;
   localparam int AW  = $clog2(CAP);

   logic          I_clk = 1'b0;
   logic          I_rst = 1'b1;
   logic          I_frame_start = 1'b0;
   logic          I_pixel_valid = 1'b0;
   logic [PW-1:0] I_pixel_data [0:CH-1];
   logic [BW-1:0] O_data_out   [0:CH-1];
   logic [AW-1:0] O_address_out;
   logic          O_clk_out, O_drop, O_overflow;

   channel_batch_packer #(
      .CHANNEL_NUMBER(CH), .CHANNEL_BANDWIDTH(BW), .BANK_DEPTH(BD), .PIXEL_WIDTH(PW)
   ) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_frame_start(I_frame_start),
      .I_pixel_valid(I_pixel_valid), .I_pixel_data(I_pixel_data),
      .O_data_out(O_data_out), .O_address_out(O_address_out),
      .O_clk_out(O_clk_out), .O_drop(O_drop), .O_overflow(O_overflow)
   );

   always #5 I_clk = ~I_clk;

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pixels of the open batch are kept as a queue; a batch is the pixels
   // concatenated with the first one in the LSBs.
   typedef enum {M_IDLE, M_FILL, M_FULL} mode_t;
   mode_t           m_mode = M_IDLE;
   logic [CH*PW-1:0] pq[$];
   int              m_batch = 0;
   logic            m_pend = 1'b0;
   logic [BW-1:0]   e_data [0:CH-1] = '{default: '0};
   logic [AW-1:0]   e_addr = '0;
   logic            e_clk = 1'b0, e_drop = 1'b0, e_ovf = 1'b0;
   int              cyc = 0;
   logic            mon_en = 1'b0;

   function automatic logic [CH*PW-1:0] cur_pixel();
      logic [CH*PW-1:0] p;
      for (int c = 0; c < CH; c++) p[c*PW +: PW] = I_pixel_data[c];
      return p;
   endfunction

   always @(posedge I_clk) begin
      logic done;
      logic [CH*PW-1:0] p;
      logic [BW-1:0] w;
      cyc++;
      mon_en = 1'b1;
      if (I_rst) begin
         m_mode = M_IDLE; m_batch = 0; m_pend = 1'b0; pq.delete();
         e_clk = 1'b0; e_drop = 1'b0; e_ovf = 1'b0; e_addr = '0;
         for (int c = 0; c < CH; c++) e_data[c] = '0;
      end else begin
         done   = 1'b0;
         e_clk  = m_pend;
         m_pend = 1'b0;
         e_drop = 1'b0;
         if (m_mode == M_FILL && I_pixel_valid && pq.size() == PPB - 1) begin
            pq.push_back(cur_pixel());
            for (int c = 0; c < CH; c++) begin
               w = '0;
               for (int k = 0; k < pq.size(); k++) begin
                  p = pq[k];
                  w = w | (BW'(p[c*PW +: PW]) << (k * PW));
               end
               e_data[c] = w;
            end
            e_addr = AW'(m_batch);
            m_pend = 1'b1;
            pq.delete();
            m_batch++;
            if (m_batch == CAP) m_mode = M_FULL;
            done = 1'b1;
         end
         if (I_frame_start) begin
            if (!done && pq.size() != 0) e_drop = 1'b1;
            pq.delete();
            m_batch = 0;
            e_ovf   = 1'b0;
            m_mode  = M_FILL;
            if (!done && I_pixel_valid) pq.push_back(cur_pixel());
         end else if (!done && I_pixel_valid) begin
            if (m_mode == M_FILL)      pq.push_back(cur_pixel());
            else if (m_mode == M_FULL) e_ovf = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   int   st_cyc[$];
   int   st_addr[$];
   int   drop_total = 0;
   logic clk_prev = 1'b0;

   always @(negedge I_clk) begin
      if (mon_en) begin
         for (int c = 0; c < CH; c++) check($sformatf("model data_out[%0d]", c), O_data_out[c], e_data[c]);
         check("model address_out", BW'(O_address_out), BW'(e_addr));
         check("model clk_out", BW'(O_clk_out), BW'(e_clk));
         check("model drop", BW'(O_drop), BW'(e_drop));
         check("model overflow", BW'(O_overflow), BW'(e_ovf));
         if (O_clk_out && !clk_prev) begin
            st_cyc.push_back(cyc);
            st_addr.push_back(int'(O_address_out));
         end
         clk_prev = O_clk_out;
         if (O_drop) drop_total++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic fs, input logic v, input logic [PW-1:0] r, g, b);
      I_frame_start   = fs;
      I_pixel_valid   = v;
      I_pixel_data[0] = r;
      I_pixel_data[1] = g;
      I_pixel_data[2] = b;
      @(posedge I_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic rnd_px(input logic fs, input logic v);
      drive(fs, v, PW'($urandom), PW'($urandom), PW'($urandom));
   endtask

   task automatic pat_px(input logic fs, input int k);
      drive(fs, 1'b1, PW'(k), PW'(8'h10 + k), PW'(8'h20 + k));
   endtask

   task automatic do_reset(input int n);
      I_rst = 1'b1;
      idle(n);
      I_rst = 1'b0;
   endtask

   // Scenario table: frame start arriving after `pre` accepted pixels.
   typedef struct {
      int   pre;
      logic fsv;
      int   post;
      int   exp_strobes;
      int   exp_drops;
      int   exp_last_addr;
   } row_t;

   logic [BW-1:0] pat_w [0:CH-1];
   row_t rows [7];

   initial begin
      int sb, db;
      I_pixel_data = '{default: '0};

      rows[0] = '{pre: 5,  fsv: 1'b1, post: 15, exp_strobes: 1, exp_drops: 1, exp_last_addr: 0};
      rows[1] = '{pre: 15, fsv: 1'b1, post: 16, exp_strobes: 2, exp_drops: 0, exp_last_addr: 0};
      rows[2] = '{pre: 15, fsv: 1'b0, post: 16, exp_strobes: 1, exp_drops: 1, exp_last_addr: 0};
      rows[3] = '{pre: 16, fsv: 1'b1, post: 15, exp_strobes: 2, exp_drops: 0, exp_last_addr: 0};
      rows[4] = '{pre: 32, fsv: 1'b0, post: 0,  exp_strobes: 2, exp_drops: 0, exp_last_addr: 1};
      rows[5] = '{pre: 1,  fsv: 1'b1, post: 0,  exp_strobes: 0, exp_drops: 1, exp_last_addr: 0};
      rows[6] = '{pre: 0,  fsv: 1'b0, post: 0,  exp_strobes: 0, exp_drops: 0, exp_last_addr: 0};

      for (int c = 0; c < CH; c++)
         for (int k = 0; k < PPB; k++) pat_w[c][k*PW +: PW] = PW'(c * 16 + k);

      // Reset state.
      do_reset(3);
      for (int c = 0; c < CH; c++) check($sformatf("reset data_out[%0d]", c), O_data_out[c], '0);
      check("reset address_out", BW'(O_address_out), '0);
      check("reset clk_out", BW'(O_clk_out), '0);
      check("reset drop", BW'(O_drop), '0);
      check("reset overflow", BW'(O_overflow), '0);

      // First batch, known pattern, exact strobe timing.
      pat_px(1'b1, 0);
      for (int k = 1; k < PPB - 1; k++) pat_px(1'b0, k);
      check("pattern data before edge 16", O_data_out[0], '0);
      pat_px(1'b0, PPB - 1);
      for (int c = 0; c < CH; c++) check($sformatf("pattern data_out[%0d]", c), O_data_out[c], pat_w[c]);
      check("pattern address", BW'(O_address_out), '0);
      check("pattern clk_out at E", BW'(O_clk_out), '0);
      idle(1);
      check("pattern clk_out at E+1", BW'(O_clk_out), BW'(1));
      idle(1);
      check("pattern clk_out at E+2", BW'(O_clk_out), '0);

      // 48 back-to-back pixels: three strobes, 16 cycles apart.
      do_reset(2);
      sb = st_cyc.size();
      rnd_px(1'b1, 1'b1);
      for (int k = 1; k < 3 * PPB; k++) rnd_px(1'b0, 1'b1);
      idle(3);
      check("burst strobe count", BW'(st_cyc.size() - sb), BW'(3));
      if (st_cyc.size() - sb == 3) begin
         for (int i = 0; i < 3; i++) check($sformatf("burst addr %0d", i), BW'(st_addr[sb+i]), BW'(i));
         check("burst spacing 0-1", BW'(st_cyc[sb+1] - st_cyc[sb]), BW'(PPB));
         check("burst spacing 1-2", BW'(st_cyc[sb+2] - st_cyc[sb+1]), BW'(PPB));
      end

      // Valid toggling every other cycle stretches the batch, same data.
      do_reset(2);
      sb = st_cyc.size();
      pat_px(1'b1, 0);
      for (int k = 1; k < PPB; k++) begin
         drive(1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC);
         pat_px(1'b0, k);
      end
      for (int c = 0; c < CH; c++) check($sformatf("gapped data_out[%0d]", c), O_data_out[c], pat_w[c]);
      check("gapped address", BW'(O_address_out), '0);
      idle(2);
      check("gapped strobe count", BW'(st_cyc.size() - sb), BW'(1));

      // Frame-start scenario table.
      foreach (rows[r]) begin
         do_reset(2);
         sb = st_cyc.size();
         db = drop_total;
         rnd_px(1'b1, rows[r].pre > 0);
         for (int k = 1; k < rows[r].pre; k++) rnd_px(1'b0, 1'b1);
         rnd_px(1'b1, rows[r].fsv);
         for (int k = 0; k < rows[r].post; k++) rnd_px(1'b0, 1'b1);
         idle(3);
         check($sformatf("row %0d strobes", r), BW'(st_cyc.size() - sb), BW'(rows[r].exp_strobes));
         check($sformatf("row %0d drops", r), BW'(drop_total - db), BW'(rows[r].exp_drops));
         if (rows[r].exp_strobes > 0 && st_addr.size() > sb)
            check($sformatf("row %0d last addr", r), BW'(st_addr[st_addr.size()-1]), BW'(rows[r].exp_last_addr));
      end

      // Full frame, then excess pixels.
      do_reset(2);
      sb = st_cyc.size();
      rnd_px(1'b1, 1'b1);
      for (int k = 1; k < CAP * PPB; k++) rnd_px(1'b0, 1'b1);
      check("full frame last address", BW'(O_address_out), BW'(CAP - 1));
      check("overflow before excess", BW'(O_overflow), '0);
      rnd_px(1'b0, 1'b1);
      check("overflow after first excess", BW'(O_overflow), BW'(1));
      rnd_px(1'b0, 1'b1);
      rnd_px(1'b0, 1'b1);
      idle(PPB + 3);
      check("full frame strobe count", BW'(st_cyc.size() - sb), BW'(CAP));
      if (st_addr.size() > 0) check("full frame last strobe addr", BW'(st_addr[st_addr.size()-1]), BW'(CAP - 1));
      check("overflow sticky", BW'(O_overflow), BW'(1));
      drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      check("overflow cleared by frame start", BW'(O_overflow), '0);

      // Reset in the middle of a batch, and reset on the strobe-pending cycle.
      do_reset(2);
      rnd_px(1'b1, 1'b1);
      for (int k = 1; k < PPB + 10; k++) rnd_px(1'b0, 1'b1);
      do_reset(1);
      for (int c = 0; c < CH; c++) check($sformatf("midreset data_out[%0d]", c), O_data_out[c], '0);
      check("midreset address", BW'(O_address_out), '0);
      check("midreset clk_out", BW'(O_clk_out), '0);
      check("midreset drop", BW'(O_drop), '0);
      rnd_px(1'b1, 1'b1);
      for (int k = 1; k < PPB; k++) rnd_px(1'b0, 1'b1);
      db = drop_total;
      do_reset(1);
      check("pending strobe cancelled", BW'(O_clk_out), '0);
      sb = st_cyc.size();
      for (int k = 0; k < 20; k++) rnd_px(1'b0, 1'b1);
      idle(3);
      check("no strobe without frame start", BW'(st_cyc.size() - sb), '0);
      check("no drop from reset", BW'(drop_total - db), '0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         I_rst = ($urandom_range(0, 499) == 0);
         rnd_px($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
      end
      I_rst = 1'b0;
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
